// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding.
package piso_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-in handshake plus serial-out and status signals of the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             shift_en_out;
  logic             busy;
  logic             word_done;

  // Controlling side: supplies words, observes serial stream and status
  modport master (
    output data_in, data_valid,
    input  data_ready, ser_out, shift_en_out, busy, word_done
  );

  // Serializer side
  modport slave (
    input  data_in, data_valid,
    output data_ready, ser_out, shift_en_out, busy, word_done
  );

endinterface

// File: rtl/mod_counter.sv
// Up counter with synchronous clear, enable and terminal-count flag at N-1.
// Holds at N-1 rather than wrapping; the owner clears it on state entry.
module mod_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == W'(N - 1));
  assign o_tc      = i_en && w_at_last;

  // Count register: clear has priority, saturate at terminal count
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-to-serial feeder for a downstream shift register: one bit per
// clock with shift_en, then a programmable idle gap before the next word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned BIT_W   = $clog2(WIDTH);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_word_done_nxt;
  logic             w_bit_tc;
  logic             w_gap_tc;

  logic             r_data_ready;
  logic             r_ser_out;
  logic             r_shift_en;
  logic             r_busy;
  logic             r_word_done;

  // Bit counter: runs only in SHIFT, cleared everywhere else
  mod_counter #(.N(WIDTH), .W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != SHIFT),
    .i_en  (r_state == SHIFT),
    .o_tc  (w_bit_tc)
  );

  // Gap counter only exists when an idle gap is configured
  if (GAP_CYCLES > 0) begin : g_gap
    mod_counter #(.N(GAP_CYCLES), .W(GAP_W)) u_gap_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (r_state != GAP),
      .i_en  (r_state == GAP),
      .o_tc  (w_gap_tc)
    );
  end else begin : g_no_gap
    assign w_gap_tc = 1'b1;
  end

  // Next-state, next shift register contents and word_done decode
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_word_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.data_valid) begin
          w_shreg_nxt = bus.data_in;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (MSB_FIRST) begin
          w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
          w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
        end
        if (w_bit_tc) begin
          w_word_done_nxt = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (w_gap_tc) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, data and output registers; outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_data_ready <= 1'b1;
      r_ser_out    <= 1'b0;
      r_shift_en   <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_data_ready <= (w_state_nxt == IDLE);
      r_ser_out    <= (w_state_nxt == SHIFT) && w_shreg_nxt[OUT_IDX];
      r_shift_en   <= (w_state_nxt == SHIFT);
      r_busy       <= (w_state_nxt != IDLE);
      r_word_done  <= w_word_done_nxt;
    end
  end

  assign bus.data_ready   = r_data_ready;
  assign bus.ser_out      = r_ser_out;
  assign bus.shift_en_out = r_shift_en;
  assign bus.busy         = r_busy;
  assign bus.word_done    = r_word_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first instance (gap 2) plus an
// LSB-first instance, each feeding a model of the downstream receiver.
module tb_piso_serializer;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  piso_serializer_if #(.WIDTH(8)) b_msb ();
  piso_serializer_if #(.WIDTH(8)) b_lsb ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (b_msb)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (b_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-bit left shift register fed by the MSB-first instance
  logic [7:0] rx;
  always_ff @(posedge clk) begin
    if (rst) rx <= 8'h00;
    else if (b_msb.shift_en_out) rx <= {rx[6:0], b_msb.ser_out};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b_msb.data_ready && !b_msb.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!ok) begin
      $display("FAIL %s_idle_timeout: data_ready never returned", name);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b_msb.data_valid = 1'b1;
    b_msb.data_in    = 8'hB5;
    tick();
    tick();
    n_vec += 4;
    if (b_msb.data_ready !== 1'b1) begin $display("FAIL rst_ready: got %b expected 1", b_msb.data_ready); n_err++; end
    if (b_msb.shift_en_out !== 1'b0) begin $display("FAIL rst_shift_en: got %b expected 0", b_msb.shift_en_out); n_err++; end
    if (b_msb.ser_out !== 1'b0) begin $display("FAIL rst_ser_out: got %b expected 0", b_msb.ser_out); n_err++; end
    if (b_msb.busy !== 1'b0) begin $display("FAIL rst_busy: got %b expected 0", b_msb.busy); n_err++; end
    b_msb.data_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_vec += 2;
    if (b_msb.busy !== 1'b0) begin $display("FAIL rst_no_accept_busy: got %b expected 0", b_msb.busy); n_err++; end
    if (b_msb.word_done !== 1'b0) begin $display("FAIL rst_word_done: got %b expected 0", b_msb.word_done); n_err++; end
  endtask

  task automatic test_basic_msb();
    logic [7:0] exp_bits;
    int         done_cnt;
    exp_bits = 8'b1011_0101;
    done_cnt = 0;
    wait_idle("basic");
    b_msb.data_in    = 8'hB5;
    b_msb.data_valid = 1'b1;
    tick();
    b_msb.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec += 3;
      if (b_msb.shift_en_out !== 1'b1) begin $display("FAIL basic_en[%0d]: got %b expected 1", i, b_msb.shift_en_out); n_err++; end
      if (b_msb.ser_out !== exp_bits[7-i]) begin $display("FAIL basic_bit[%0d]: got %b expected %b", i, b_msb.ser_out, exp_bits[7-i]); n_err++; end
      if (b_msb.data_ready !== 1'b0) begin $display("FAIL basic_ready[%0d]: got %b expected 0", i, b_msb.data_ready); n_err++; end
      if (b_msb.word_done === 1'b1) done_cnt++;
      tick();
    end
    n_vec += 5;
    if (b_msb.word_done !== 1'b1) begin $display("FAIL basic_word_done: got %b expected 1", b_msb.word_done); n_err++; end
    if (b_msb.shift_en_out !== 1'b0) begin $display("FAIL basic_gap_en: got %b expected 0", b_msb.shift_en_out); n_err++; end
    if (b_msb.busy !== 1'b1) begin $display("FAIL basic_gap_busy: got %b expected 1", b_msb.busy); n_err++; end
    if (rx !== 8'hB5) begin $display("FAIL basic_rx: got %h expected b5", rx); n_err++; end
    if (b_msb.word_done === 1'b1) done_cnt++;
    tick();
    if (b_msb.word_done === 1'b1) done_cnt++;
    if (done_cnt != 1) begin $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); n_err++; end
  endtask

  task automatic test_back_to_back();
    logic [18:0] en_exp;
    logic [18:0] ser_exp;
    logic [18:0] rdy_exp;
    en_exp  = 19'b1111_1111_000_1111_1111;
    ser_exp = {8'hB5, 3'b000, 8'h3C};
    rdy_exp = 19'b0000_0000_001_0000_0000;
    wait_idle("b2b");
    b_msb.data_in    = 8'hB5;
    b_msb.data_valid = 1'b1;
    tick();
    b_msb.data_in = 8'h3C;
    for (int i = 0; i < 19; i++) begin
      if (i == 11) b_msb.data_valid = 1'b0;
      n_vec += 3;
      if (b_msb.shift_en_out !== en_exp[18-i]) begin $display("FAIL b2b_en[%0d]: got %b expected %b", i, b_msb.shift_en_out, en_exp[18-i]); n_err++; end
      if (b_msb.ser_out !== ser_exp[18-i]) begin $display("FAIL b2b_ser[%0d]: got %b expected %b", i, b_msb.ser_out, ser_exp[18-i]); n_err++; end
      if (b_msb.data_ready !== rdy_exp[18-i]) begin $display("FAIL b2b_ready[%0d]: got %b expected %b", i, b_msb.data_ready, rdy_exp[18-i]); n_err++; end
      tick();
    end
    n_vec++;
    if (rx !== 8'h3C) begin $display("FAIL b2b_rx: got %h expected 3c", rx); n_err++; end
  endtask

  task automatic test_ignore_busy();
    logic [18:0] en_exp;
    logic [18:0] ser_exp;
    logic [18:0] rdy_exp;
    en_exp  = 19'b1111_1111_000_1111_1111;
    ser_exp = {8'h3C, 3'b000, 8'hFF};
    rdy_exp = 19'b0000_0000_001_0000_0000;
    wait_idle("ignore");
    b_msb.data_in    = 8'h3C;
    b_msb.data_valid = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      if (i == 3) b_msb.data_in = 8'hFF;
      if (i == 11) b_msb.data_valid = 1'b0;
      n_vec += 3;
      if (b_msb.shift_en_out !== en_exp[18-i]) begin $display("FAIL ignore_en[%0d]: got %b expected %b", i, b_msb.shift_en_out, en_exp[18-i]); n_err++; end
      if (b_msb.ser_out !== ser_exp[18-i]) begin $display("FAIL ignore_ser[%0d]: got %b expected %b", i, b_msb.ser_out, ser_exp[18-i]); n_err++; end
      if (b_msb.data_ready !== rdy_exp[18-i]) begin $display("FAIL ignore_ready[%0d]: got %b expected %b", i, b_msb.data_ready, rdy_exp[18-i]); n_err++; end
      tick();
    end
    n_vec++;
    if (rx !== 8'hFF) begin $display("FAIL ignore_rx: got %h expected ff", rx); n_err++; end
  endtask

  task automatic test_lsb_first();
    logic [7:0] words [2];
    logic [7:0] seqs  [2];
    words[0] = 8'h01; seqs[0] = 8'b1000_0000;
    words[1] = 8'hB5; seqs[1] = 8'b1010_1101;
    for (int w = 0; w < 2; w++) begin
      n_vec++;
      if (b_lsb.data_ready !== 1'b1) begin $display("FAIL lsb_ready_w%0d: got %b expected 1", w, b_lsb.data_ready); n_err++; end
      b_lsb.data_in    = words[w];
      b_lsb.data_valid = 1'b1;
      tick();
      b_lsb.data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        n_vec += 2;
        if (b_lsb.shift_en_out !== 1'b1) begin $display("FAIL lsb_en_w%0d[%0d]: got %b expected 1", w, i, b_lsb.shift_en_out); n_err++; end
        if (b_lsb.ser_out !== seqs[w][7-i]) begin $display("FAIL lsb_bit_w%0d[%0d]: got %b expected %b", w, i, b_lsb.ser_out, seqs[w][7-i]); n_err++; end
        tick();
      end
      n_vec += 2;
      if (b_lsb.word_done !== 1'b1) begin $display("FAIL lsb_word_done_w%0d: got %b expected 1", w, b_lsb.word_done); n_err++; end
      if (b_lsb.ser_out !== 1'b0) begin $display("FAIL lsb_gap_ser_w%0d: got %b expected 0", w, b_lsb.ser_out); n_err++; end
      tick();
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] first3;
    logic [7:0] exp_bits;
    first3   = 8'b1010_0000;
    exp_bits = 8'b1010_0101;
    wait_idle("rstmid");
    b_msb.data_in    = 8'hB5;
    b_msb.data_valid = 1'b1;
    tick();
    b_msb.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (b_msb.ser_out !== first3[7-i]) begin $display("FAIL rstmid_pre_bit[%0d]: got %b expected %b", i, b_msb.ser_out, first3[7-i]); n_err++; end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec += 3;
    if (b_msb.shift_en_out !== 1'b0) begin $display("FAIL rstmid_en: got %b expected 0", b_msb.shift_en_out); n_err++; end
    if (b_msb.data_ready !== 1'b1) begin $display("FAIL rstmid_ready: got %b expected 1", b_msb.data_ready); n_err++; end
    if (b_msb.busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b expected 0", b_msb.busy); n_err++; end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (b_msb.word_done !== 1'b0 || b_msb.shift_en_out !== 1'b0) begin
        $display("FAIL rstmid_quiet[%0d]: got done=%b en=%b expected 0 0", i, b_msb.word_done, b_msb.shift_en_out);
        n_err++;
      end
      tick();
    end
    b_msb.data_in    = 8'hA5;
    b_msb.data_valid = 1'b1;
    tick();
    b_msb.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_vec += 2;
      if (b_msb.shift_en_out !== 1'b1) begin $display("FAIL rstmid_a5_en[%0d]: got %b expected 1", i, b_msb.shift_en_out); n_err++; end
      if (b_msb.ser_out !== exp_bits[7-i]) begin $display("FAIL rstmid_a5_bit[%0d]: got %b expected %b", i, b_msb.ser_out, exp_bits[7-i]); n_err++; end
      tick();
    end
    n_vec += 2;
    if (rx !== 8'hA5) begin $display("FAIL rstmid_rx: got %h expected a5", rx); n_err++; end
    if (b_msb.word_done !== 1'b1) begin $display("FAIL rstmid_a5_done: got %b expected 1", b_msb.word_done); n_err++; end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst              = 1'b1;
    b_msb.data_in    = 8'h00;
    b_msb.data_valid = 1'b0;
    b_lsb.data_in    = 8'h00;
    b_lsb.data_valid = 1'b0;
    test_reset();
    test_basic_msb();
    test_back_to_back();
    test_ignore_busy();
    test_lsb_first();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
